// File: rtl/mul_div_unit.sv
// Multi-cycle signed multiply/divide engine feeding the ZHigh/ZLow register pair.
// Multiply is radix-4 Booth; divide is non-restoring on magnitudes with a sign-fix cycle.
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] z_high,
  output logic [WIDTH-1:0] z_low
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] MUL_LAST = CW'(WIDTH/2 - 1);
  localparam logic [CW-1:0] DIV_LAST = CW'(WIDTH - 1);

  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_DIV_FIX, S_DONE} state_t;

  state_t             state;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH:0]     mplier;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   dvsr;
  logic [WIDTH+1:0]   rem;
  logic [WIDTH-1:0]   quo;
  logic               a_neg;
  logic               b_neg;

  logic [2*WIDTH-1:0] booth_term;
  logic [2*WIDTH-1:0] acc_next;
  logic [WIDTH+1:0]   rem_sh;
  logic [WIDTH+1:0]   rem_next;
  logic [WIDTH+1:0]   rem_fix;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;

  // Booth digit from the low triplet of the (appended-zero) multiplier.
  always_comb begin
    booth_term = '0;
    case (mplier[2:0])
      3'b001, 3'b010: booth_term = mcand;
      3'b011:         booth_term = mcand << 1;
      3'b100:         booth_term = -(mcand << 1);
      3'b101, 3'b110: booth_term = -mcand;
      default:        booth_term = '0;
    endcase
    acc_next = acc + booth_term;
  end

  always_comb begin
    a_mag    = operand_a[WIDTH-1] ? -operand_a : operand_a;
    b_mag    = operand_b[WIDTH-1] ? -operand_b : operand_b;
    rem_sh   = {rem[WIDTH:0], quo[WIDTH-1]};
    rem_next = rem[WIDTH+1] ? rem_sh + {2'b00, dvsr} : rem_sh - {2'b00, dvsr};
    rem_fix  = rem[WIDTH+1] ? rem + {2'b00, dvsr} : rem;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      cnt         <= '0;
      mcand       <= '0;
      mplier      <= '0;
      acc         <= '0;
      dvsr        <= '0;
      rem         <= '0;
      quo         <= '0;
      a_neg       <= 1'b0;
      b_neg       <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      z_high      <= '0;
      z_low       <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            div_by_zero <= 1'b0;
            a_neg       <= operand_a[WIDTH-1];
            b_neg       <= operand_b[WIDTH-1];
            mcand       <= {{WIDTH{operand_a[WIDTH-1]}}, operand_a};
            mplier      <= {operand_b, 1'b0};
            acc         <= '0;
            dvsr        <= b_mag;
            rem         <= '0;
            quo         <= a_mag;
            if (!op) begin
              cnt   <= MUL_LAST;
              state <= S_MUL;
              busy  <= 1'b1;
            end else if (operand_b == '0) begin
              cnt         <= '0;
              z_high      <= operand_a;
              z_low       <= '0;
              div_by_zero <= 1'b1;
              state       <= S_DONE;
              done        <= 1'b1;
            end else begin
              cnt   <= DIV_LAST;
              state <= S_DIV;
              busy  <= 1'b1;
            end
          end
        end
        S_MUL: begin
          acc    <= acc_next;
          mcand  <= mcand << 2;
          mplier <= {{2{mplier[WIDTH]}}, mplier[WIDTH:2]};
          if (cnt == '0) begin
            z_high <= acc_next[2*WIDTH-1:WIDTH];
            z_low  <= acc_next[WIDTH-1:0];
            state  <= S_DONE;
            busy   <= 1'b0;
            done   <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_DIV: begin
          rem <= rem_next;
          quo <= {quo[WIDTH-2:0], ~rem_next[WIDTH+1]};
          if (cnt == '0) state <= S_DIV_FIX;
          else           cnt   <= cnt - 1'b1;
        end
        S_DIV_FIX: begin
          // Magnitude quotient of -2^(W-1)/-1 already equals the wrapped result.
          z_low  <= (a_neg ^ b_neg) ? -quo : quo;
          z_high <= a_neg ? -rem_fix[WIDTH-1:0] : rem_fix[WIDTH-1:0];
          state  <= S_DONE;
          busy   <= 1'b0;
          done   <= 1'b1;
        end
        S_DONE: begin
          state <= S_IDLE;
          done  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed-vector bench for mul_div_unit: results, latency, busy window, flags, abort.
module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        op;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic        busy;
  logic        done;
  logic        div_by_zero;
  logic [31:0] z_high;
  logic [31:0] z_low;

  int n_checks = 0;
  int n_pass   = 0;

  mul_div_unit #(.WIDTH(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .op          (op),
    .operand_a   (operand_a),
    .operand_b   (operand_b),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .z_high      (z_high),
    .z_low       (z_low)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Latency counts rising edges after the accepting edge until done is seen;
  // a divide-by-zero reaches DONE on the accepting edge itself.
  task automatic run(input string tag, input logic o, input logic [31:0] a, input logic [31:0] b,
                     input int exp_lat, input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                     input logic exp_dbz);
    int n;
    int busy_cnt;
    start = 1'b1; op = o; operand_a = a; operand_b = b;
    @(posedge clk); #1;
    start = 1'b0; operand_a = $urandom; operand_b = $urandom;
    n = 0; busy_cnt = 0;
    while (!done && n < 100) begin
      if (busy) busy_cnt++;
      @(posedge clk); #1;
      n++;
    end
    check({tag, " latency"}, 64'(n), 64'(exp_lat));
    check({tag, " busy cycles"}, 64'(busy_cnt), 64'(exp_lat));
    check({tag, " z_high"}, {32'h0, z_high}, {32'h0, exp_hi});
    check({tag, " z_low"}, {32'h0, z_low}, {32'h0, exp_lo});
    check({tag, " div_by_zero"}, {63'h0, div_by_zero}, {63'h0, exp_dbz});
    check({tag, " busy at done"}, {63'h0, busy}, 64'h0);
    @(posedge clk); #1;
    check({tag, " done one pulse"}, {63'h0, done}, 64'h0);
  endtask

  initial begin
    int n;
    logic saw_done;
    reset = 1'b1; start = 1'b0; op = 1'b0; operand_a = '0; operand_b = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset busy", {63'h0, busy}, 64'h0);
    check("reset done", {63'h0, done}, 64'h0);
    check("reset dbz", {63'h0, div_by_zero}, 64'h0);
    check("reset z", {z_high, z_low}, 64'h0);
    reset = 1'b0;
    @(posedge clk); #1;

    run("mul 7*-3",      1'b0, 32'd7,        32'hFFFFFFFD, 16, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0);
    run("mul min*min",   1'b0, 32'h80000000, 32'h80000000, 16, 32'h40000000, 32'h00000000, 1'b0);
    run("mul -1*-1",     1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 16, 32'h00000000, 32'h00000001, 1'b0);
    run("mul max*max",   1'b0, 32'h7FFFFFFF, 32'h7FFFFFFF, 16, 32'h3FFFFFFF, 32'h00000001, 1'b0);
    run("mul x*16",      1'b0, 32'h12345678, 32'h00000010, 16, 32'h00000001, 32'h23456780, 1'b0);
    run("div -7/2",      1'b1, 32'hFFFFFFF9, 32'd2,        33, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
    run("div 100/7",     1'b1, 32'd100,      32'd7,        33, 32'd2,        32'd14,       1'b0);
    run("div -100/7",    1'b1, 32'hFFFFFF9C, 32'd7,        33, 32'hFFFFFFFE, 32'hFFFFFFF2, 1'b0);
    run("div 100/-7",    1'b1, 32'd100,      32'hFFFFFFF9, 33, 32'd2,        32'hFFFFFFF2, 1'b0);
    run("div by zero",   1'b1, 32'h12345678, 32'd0,        0,  32'h12345678, 32'h00000000, 1'b1);
    run("mul clears dbz",1'b0, 32'd3,        32'd5,        16, 32'h0,        32'd15,       1'b0);
    run("div overflow",  1'b1, 32'h80000000, 32'hFFFFFFFF, 33, 32'h0,        32'h80000000, 1'b0);

    // Second start during a multiply must be ignored.
    start = 1'b1; op = 1'b0; operand_a = 32'd7; operand_b = 32'hFFFFFFFD;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (!done && n < 100) begin
      @(posedge clk); #1;
      n++;
      if (n == 5) begin
        start = 1'b1; op = 1'b1; operand_a = 32'd99; operand_b = 32'd4;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    check("busy-start latency", 64'(n), 64'd16);
    check("busy-start result", {z_high, z_low}, 64'hFFFFFFFF_FFFFFFEB);
    repeat (3) @(posedge clk);
    #1;
    check("busy-start no requeue", {63'h0, busy}, 64'h0);

    // Reset in the middle of a divide aborts without a done pulse.
    start = 1'b1; op = 1'b1; operand_a = 32'd100; operand_b = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    saw_done = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk); #1;
      if (done) saw_done = 1'b1;
    end
    reset = 1'b1;
    #1;
    check("abort busy", {63'h0, busy}, 64'h0);
    check("abort z", {z_high, z_low}, 64'h0);
    repeat (2) begin
      @(posedge clk); #1;
      if (done) saw_done = 1'b1;
    end
    reset = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done) saw_done = 1'b1;
    end
    check("abort no done", {63'h0, saw_done}, 64'h0);
    run("div after abort", 1'b1, 32'd100, 32'd7, 33, 32'd2, 32'd14, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
